wgt_loader: RTL

Weight loader for the 3x3 convolution unit. It reads one 3x3 signed 8-bit kernel from the weight SRAM and pushes it, row by row, into the three per-row weight register files. Each register file is a 3-deep shift register that shifts when its read strobe is high. The loader sits between the weight SRAM and the PE array's weight register files, and the layer controller starts it with a single pulse.

---
 rtl/wgt_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wgt_loader.sv
// Weight loader for the 3x3 convolution unit.
// Fetches one 3x3 signed 8-bit kernel from the weight SRAM (row-major at
// base_addr) and streams it onto a shared weight bus. Each weight is paired
// with a shift strobe for the register file of its kernel row.
module wgt_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_ren,
    output logic [ADDR_W-1:0]    sram_addr,
    input  logic signed [7:0]    sram_rdata,
    output logic signed [7:0]    wgt_out,
    output logic                 wgt_read0,
    output logic                 wgt_read1,
    output logic                 wgt_read2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    // idx is the kernel index of the read currently on the SRAM port
    logic [3:0]          idx;
    logic [3:0]          idx_inc;
    logic [ADDR_W-1:0]   base_q;
    logic                accept;
    logic                last_issue;
    logic [1:0]          issue_row;

    // Return pipeline: marks the cycle in which sram_rdata holds a weight
    logic                ret_valid;
    logic [1:0]          ret_row;

    assign idx_inc    = idx + 4'd1;
    assign last_issue = (state == FETCH) && (idx == 4'd8);
    assign issue_row  = (idx < 4'd3) ? 2'd0 : ((idx < 4'd6) ? 2'd1 : 2'd2);

    // State register; reset abandons any load in progress
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus busy/done decode; start is honoured only when not busy
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read issue: latch the base on accept, then step the address once per FETCH cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx       <= 4'd0;
            base_q    <= '0;
            sram_ren  <= 1'b0;
            sram_addr <= '0;
        end else if (accept) begin
            idx       <= 4'd0;
            base_q    <= base_addr;
            sram_ren  <= 1'b1;
            sram_addr <= base_addr;
        end else if (state == FETCH) begin
            if (last_issue) begin
                idx      <= 4'd0;
                sram_ren <= 1'b0;
            end else begin
                idx       <= idx_inc;
                sram_addr <= base_q + ADDR_W'(idx_inc);
            end
        end
    end

    // Delay the read-valid and its row tag to line up with the returning SRAM data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ret_valid <= 1'b0;
            ret_row   <= 2'd0;
        end else begin
            ret_valid <= sram_ren;
            ret_row   <= issue_row;
        end
    end

    // Drive the weight bus and exactly one row strobe while data returns, else quiet
    always_comb begin
        wgt_out   = '0;
        wgt_read0 = 1'b0;
        wgt_read1 = 1'b0;
        wgt_read2 = 1'b0;
        if (ret_valid) begin
            wgt_out = sram_rdata;
            case (ret_row)
                2'd0:    wgt_read0 = 1'b1;
                2'd1:    wgt_read1 = 1'b1;
                default: wgt_read2 = 1'b1;
            endcase
        end
    end

endmodule
